// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: three-channel 8-bit PWM with a programmable prescaler.
// Duty writes land in a pending register and are copied to the active
// compare values only at the period wrap, or continuously while disabled.
module rgb_pwm_gen #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [2:0]  pwm_out,
    output logic        period_tick
);

    typedef enum logic [1:0] {
        A_CTRL   = 2'd0,
        A_PRESC  = 2'd1,
        A_DUTY   = 2'd2,
        A_STATUS = 2'd3
    } addr_e;

    addr_e              sel;
    logic               enable;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [23:0]        pend_duty;
    logic [23:0]        act_duty;
    logic [7:0]         count;
    logic               step;
    logic               wrap;
    logic               dis_wr;
    logic               unused_wdata;

    assign sel          = addr_e'(addr);
    assign unused_wdata = ^wdata[31:24];

    // Step / wrap decode; dis_wr flags a write that clears enable this cycle.
    always_comb begin
        step   = enable && (pcnt >= presc);
        wrap   = step && (count == 8'd254);
        dis_wr = wr_en && (sel == A_CTRL) && !wdata[0];
    end

    // Firmware-visible registers written over the single-cycle port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= 1'b0;
            presc     <= '0;
            pend_duty <= '0;
        end else if (wr_en) begin
            case (sel)
                A_CTRL:  enable    <= wdata[0];
                A_PRESC: presc     <= wdata[PRESC_W-1:0];
                A_DUTY:  pend_duty <= wdata[23:0];
                default: ;
            endcase
        end
    end

    // Prescaler, period counter, double-buffered duty and registered PWM compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            count       <= '0;
            act_duty    <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else if (!enable) begin
            pcnt        <= '0;
            count       <= '0;
            act_duty    <= pend_duty;
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pcnt <= step ? '0 : pcnt + PRESC_W'(1);
            if (step) begin
                count <= wrap ? 8'd0 : count + 8'd1;
            end
            if (wrap) begin
                act_duty <= pend_duty;
            end
            // A wrap coinciding with a disabling write must not produce a
            // tick in the first disabled cycle.
            period_tick <= wrap && !dis_wr;
            for (int unsigned i = 0; i < 3; i++) begin
                pwm_out[i] <= (count < act_duty[8*i +: 8]);
            end
        end
    end

    // Combinational register readback.
    always_comb begin
        rdata = '0;
        case (sel)
            A_CTRL:   rdata[0] = enable;
            A_PRESC:  rdata[PRESC_W-1:0] = presc;
            A_DUTY:   rdata[23:0] = pend_duty;
            A_STATUS: begin
                rdata[7:0]  = count;
                rdata[15:8] = act_duty[7:0];
                rdata[16]   = enable;
            end
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// tb_rgb_pwm_gen: scoreboard bench for rgb_pwm_gen. The stimulus side knows
// when each period begins and predicts per-period high time per channel
// (duty * (presc+1)) and period length (255 * (presc+1)); a monitor
// accumulates DUT output between period ticks and compares.
module tb_rgb_pwm_gen;

    localparam int PW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  pwm_out;
    logic        period_tick;

    always #5 clk = ~clk;

    rgb_pwm_gen #(.PRESC_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    typedef struct {
        int hi0;
        int hi1;
        int hi2;
        int len;   // 0: period length not checked (first period of a run)
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_flush = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: integrates PWM high time between ticks, pops expectation on tick.
    initial begin
        int   acc0, acc1, acc2, cyc;
        exp_t e;
        acc0 = 0; acc1 = 0; acc2 = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (mon_flush) begin
                chk("sb_drained", 32'(sb.size()), 32'd0);
                sb.delete();
                acc0 = 0; acc1 = 0; acc2 = 0; cyc = 0;
            end else begin
                acc0 += int'(pwm_out[0]);
                acc1 += int'(pwm_out[1]);
                acc2 += int'(pwm_out[2]);
                cyc++;
                if (period_tick === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tick: got tick with 0 periods pending, required none");
                    end else begin
                        e = sb.pop_front();
                        chk("high_ch0", 32'(acc0), 32'(e.hi0));
                        chk("high_ch1", 32'(acc1), 32'(e.hi1));
                        chk("high_ch2", 32'(acc2), 32'(e.hi2));
                        if (e.len != 0) chk("period_len", 32'(cyc), 32'(e.len));
                    end
                    acc0 = 0; acc1 = 0; acc2 = 0; cyc = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic flush();
        mon_flush = 1'b1;
        @(posedge clk);
        #1;
        mon_flush = 1'b0;
    endtask

    task automatic push(input logic [23:0] pend, input int p, input int len);
        exp_t e;
        e.hi0 = int'(pend[7:0])   * (p + 1);
        e.hi1 = int'(pend[15:8])  * (p + 1);
        e.hi2 = int'(pend[23:16]) * (p + 1);
        e.len = len;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One enabled run of nper periods. Period k+1 uses whatever duty was
    // pending just before the edge that ends period k.
    task automatic run(input int p, input logic [23:0] d0, input int nper,
                       input bit rnd, input int sw_t, input logic [23:0] sw_v);
        int          per;
        logic [23:0] pend;
        logic [31:0] r;
        per = 255 * (p + 1);
        wr(2'd0, 32'd0);
        wr(2'd1, 32'(p));
        wr(2'd2, {8'h00, d0});
        pend = d0;
        idle(2);
        flush();
        push(pend, p, 0);
        wr(2'd0, 32'd1);
        for (int t = 1; t <= nper * per; t++) begin
            if ((t % per) == 0 && t < nper * per) push(pend, p, per);
            if (t == sw_t) begin
                addr = 2'd2; wdata = {8'h00, sw_v}; wr_en = 1'b1;
                pend = sw_v;
            end else if (rnd && $urandom_range(0, 299) == 0) begin
                r = $urandom;
                case ($urandom_range(0, 2))
                    0: begin
                        pend = {pick(), pick(), pick()};
                        addr = 2'd2; wdata = {r[31:24], pend}; wr_en = 1'b1;
                    end
                    1: begin
                        addr = 2'd3; wdata = r; wr_en = 1'b1;
                    end
                    default: begin
                        addr = 2'd0; wdata = r | 32'd1; wr_en = 1'b1;
                    end
                endcase
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
        end
        wr(2'd0, 32'd0);
        idle(3);
        flush();
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; wr_en = 1'b0; addr = 2'd0; wdata = '0;
        #12;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("rst_rdata", rdata, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        flush();

        // Register readback, write-ignored STATUS, unused CTRL bits.
        wr(2'd1, 32'hFFFF_1234);
        rd(2'd1, v); chk("rd_presc", v, 32'h0000_1234);
        wr(2'd2, 32'hAB11_2233);
        rd(2'd2, v); chk("rd_duty", v, 32'h0011_2233);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); chk("rd_status_dis", v, 32'h0000_3300);
        wr(2'd0, 32'hFFFF_FFFE);
        rd(2'd0, v); chk("rd_ctrl", v, 32'd0);

        // presc=3: count advances every 4 clocks from the enable edge.
        wr(2'd1, 32'd3);
        wr(2'd2, 32'h0000_000A);
        idle(1);
        wr(2'd0, 32'd1);
        for (int j = 0; j <= 12; j++) begin
            rd(2'd3, v);
            chk("status_presc3", v, {15'd0, 1'b1, 8'h0A, 8'(j / 4)});
            idle(1);
        end
        wr(2'd0, 32'd0);
        idle(2);
        flush();

        // presc 9 -> 1 written while pcnt=5: step next cycle, then every 2.
        wr(2'd1, 32'd9);
        wr(2'd0, 32'd1);
        idle(5);
        wr(2'd1, 32'd1);
        for (int j = 0; j < 6; j++) begin
            rd(2'd3, v);
            chk("presc_shrink_count", 32'(v[7:0]), 32'((j + 1) / 2));
            idle(1);
        end
        wr(2'd0, 32'd0);
        idle(2);
        flush();

        // Disable at count=100.
        wr(2'd1, 32'd0);
        wr(2'd2, 32'h00FF_8040);
        idle(2);
        wr(2'd0, 32'd1);
        idle(100);
        rd(2'd3, v);
        chk("dis_count100", 32'(v[7:0]), 32'd100);
        chk("dis_pwm_before", 32'(pwm_out), 32'd6);
        wr(2'd0, 32'd0);
        idle(1);
        chk("dis_pwm_after", 32'(pwm_out), 32'd0);
        rd(2'd3, v);
        chk("dis_count_after", 32'(v[7:0]), 32'd0);
        idle(2);
        flush();

        // Asynchronous reset in the middle of a running period.
        wr(2'd1, 32'd3);
        wr(2'd2, 32'h00FF_8040);
        wr(2'd0, 32'd1);
        idle(300);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_tick", 32'(period_tick), 32'd0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk("arst_rdata", rdata, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        rd(2'd3, v); chk("arst_status_after", v, 32'd0);
        flush();

        // Scoreboard runs.
        run(0, 24'hFF8000, 3, 1'b0, 0, 24'h0);
        run(3, 24'h00000A, 2, 1'b0, 0, 24'h0);
        run(0, 24'h0000C8, 2, 1'b0, 127, 24'h000032);
        run(1, 24'h102030, 3, 1'b0, 510, 24'h405060);
        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(0, 2)), {pick(), pick(), pick()}, 3, 1'b1, 0, 24'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_gen.md
# rgb_pwm_gen

Register-programmable three-channel PWM generator that produces the per-channel on/off drive consumed by the RGB LED driver block (`RGB_in[2:0]`). Firmware writes a prescaler and three 8-bit duty values over a simple single-cycle write port. The block generates glitch-free PWM, with duty updates double-buffered to the period boundary. It sits between the SoC peripheral bus bridge and `light_control`.

## Interface
- `PRESC_W`, 16, width of the prescaler register and counter
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write strobe; one write per cycle in which it is high
- `addr`  in  2  register select for both write and read
- `wdata`  in  32  write data
- `rdata`  out  32  combinational readback of register `addr`
- `pwm_out`  out  3  PWM drive; bit i feeds `RGB_in[i]`
- `period_tick`  out  1  one-cycle pulse at each PWM period wrap

Clock is `clk`. Reset is `rst`, asynchronous and active-high.

## Operation
- Register map:
  - addr 0, CTRL: bit0 `enable`. All other bits read 0.
  - addr 1, PRESC: bits [PRESC_W-1:0] `presc`.
  - addr 2, DUTY: [7:0] ch0, [15:8] ch1, [23:16] ch2. Writes go to the pending register. Reads return the pending register.
  - addr 3, STATUS: read-only. [7:0] current `count`, bits [15:8] hold active ch0 duty, bit16 `enable`. Writes are ignored.
- Prescaler:
  - While `enable`=1, `pcnt` increments each cycle.
  - When `pcnt >= presc`, `pcnt` returns to 0 and a step occurs. The comparison is `>=`, so a `presc` value written below the current `pcnt` causes a step on the next cycle.
  - `presc`=0 gives one step per clock.
- Period counter:
  - `count` (8 bits) advances by one on each step, over the range 0..254, giving 255 steps per period.
  - On a step with `count`=254, `count` returns to 0 (the wrap).
  - On the wrap, the active duties load from pending and `period_tick` pulses.
- PWM compare:
  - `pwm_out[i]` is registered as `enable && (count < active_duty[i])`.
  - Duty 0 keeps the channel low.
  - Duty 255 keeps the channel high for the whole period.
- Enable and disable:
  - While `enable`=0, `pcnt` and `count` are held at 0, `pwm_out`=0, and the active duties track pending every cycle. A DUTY write made while disabled is therefore active on the first period after enable.
  - Clearing `enable` mid-period takes effect immediately. The counters clear on the next edge, and `pwm_out` is low from the following edge onward.
- Simultaneous events:
  - A DUTY write in the same cycle as a wrap: the active duties load the old pending value, and the new value waits for the next wrap.
  - A PRESC write during counting takes effect for the current compare on the next cycle.
- Reset:
  - Asynchronous reset clears all state at any point, including mid-period: CTRL=0, presc=0, pending=0, active=0, pcnt=0, count=0, `pwm_out`=0, `period_tick`=0.
  - `rdata` then reads 0 for every address.

## Timing
- Writes are captured on the `clk` rising edge where `wr_en`=1. The new value is visible on `rdata` in the following cycle.
- `enable` written 1 at edge E:
  - First step is at edge E+1+presc.
  - `pwm_out` is first valid (count=0 compare) at edge E+1.
- `pwm_out` lags `count` by one cycle.
- `period_tick` is asserted in the cycle after the edge at which `count` wraps to 0. It is never high while disabled.
- Period length is 255·(presc+1) clocks. High time for channel i is duty_i·(presc+1) clocks.

## Test plan
- Reset mid-run: enable=1, presc=3, DUTY=0x00FF8040, assert `rst` asynchronously at an arbitrary phase → `pwm_out`=000 and `period_tick`=0 immediately; all four addresses read 0.
- Basic duty: presc=0, DUTY=0x00FF8000, enable=1 → ch0 always 0; ch1 high 128 of every 255 clocks; ch2 constantly 1; `period_tick` pulses every 255 clocks.
- Prescaler: presc=3, ch0 duty=10 → ch0 high for 40 clocks per 1020-clock period; STATUS[7:0] increments every 4 clocks.
- Double buffering: running with ch0=200, write ch0=50 mid-period → the current period keeps 200 steps high, and the next period after `period_tick` has 50.
- Write coinciding with wrap: DUTY write lands in the same cycle `count` goes 254→0 → old pending loads now; the new value applies one period later.
- Disable mid-period and PRESC shrink: clear enable at count=100 → `pwm_out`=000 within 2 edges, and count=0. Separately, write presc=1 while pcnt=5 under presc=9 → step occurs on the next cycle, then steps every 2 clocks.
